// File: rtl/qdrc_rd_tagged.sv
// QDR read-path tracker: gates user read strobes, tags accepted reads and
// realigns returned PHY data through a latency-programmable delay line.
module qdrc_rd_tagged #(
   parameter int DATA_WIDTH      = 36,
   parameter int TAG_WIDTH       = 4,
   parameter int MAX_LATENCY     = 16,
   parameter int DEFAULT_LATENCY = 11,
   parameter int LAT_W           = 5,
   parameter int CNT_W           = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    phy_rdy,
   input  logic                    usr_strb,
   input  logic [TAG_WIDTH-1:0]    usr_tag,
   output logic                    usr_rej,
   output logic                    phy_strb,
   input  logic [2*DATA_WIDTH-1:0] phy_data,
   output logic [2*DATA_WIDTH-1:0] usr_data,
   output logic [TAG_WIDTH-1:0]    usr_tag_out,
   output logic                    usr_dvld,
   input  logic [LAT_W-1:0]        lat_cfg,
   input  logic                    lat_load,
   output logic                    lat_err,
   output logic [LAT_W-1:0]        lat_cur,
   output logic [CNT_W-1:0]        outstanding
);

   localparam int IDX_W = (MAX_LATENCY > 2) ? $clog2(MAX_LATENCY) : 1;

   logic                                  blk_reg;
   logic                                  accept;
   logic                                  lat_ok;
   logic [LAT_W-1:0]                      lat_clamped;
   logic [LAT_W-1:0]                      lat_cur_reg;
   logic [IDX_W-1:0]                      tap_idx;
   logic [MAX_LATENCY-1:0]                vld_reg;
   logic [MAX_LATENCY-1:0]                vld_next;
   logic [MAX_LATENCY-1:0][TAG_WIDTH-1:0] tag_reg;
   logic [MAX_LATENCY-1:0][TAG_WIDTH-1:0] tag_next;
   logic                                  usr_rej_reg;
   logic                                  usr_dvld_reg;
   logic [TAG_WIDTH-1:0]                  usr_tag_reg;
   logic [2*DATA_WIDTH-1:0]               usr_data_reg;
   logic                                  lat_err_reg;
   logic [CNT_W-1:0]                      outstanding_reg;
   logic [CNT_W-1:0]                      outstanding_next;

   // A burst-of-4 occupies two controller cycles, so the cycle after an accept is blocked.
   assign accept   = usr_strb & phy_rdy & ~blk_reg;
   assign phy_strb = accept;

   // Latency may only change when nothing is in flight or being launched.
   assign lat_ok = lat_load & (outstanding_reg == '0) & ~accept;

   always_comb begin
      lat_clamped = lat_cfg;
      if (lat_cfg < LAT_W'(2))
         lat_clamped = LAT_W'(2);
      else if (lat_cfg > LAT_W'(MAX_LATENCY))
         lat_clamped = LAT_W'(MAX_LATENCY);
   end

   // Stage k holds a read accepted k+1 cycles ago; the output register adds one more.
   assign tap_idx = IDX_W'(lat_cur_reg - LAT_W'(2));

   assign vld_next[0] = accept;
   assign tag_next[0] = usr_tag;

   genvar gi;
   generate
      for (gi = 1; gi < MAX_LATENCY; gi++) begin : g_stage
         assign vld_next[gi] = vld_reg[gi-1];
         assign tag_next[gi] = tag_reg[gi-1];
      end
   endgenerate

   always_comb begin
      outstanding_next = outstanding_reg;
      case ({accept, usr_dvld_reg})
         2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
         2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
         default: outstanding_next = outstanding_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blk_reg         <= 1'b0;
         usr_rej_reg     <= 1'b0;
         lat_err_reg     <= 1'b0;
         lat_cur_reg     <= LAT_W'(DEFAULT_LATENCY);
         vld_reg         <= '0;
         tag_reg         <= '0;
         usr_dvld_reg    <= 1'b0;
         usr_tag_reg     <= '0;
         usr_data_reg    <= '0;
         outstanding_reg <= '0;
      end else begin
         blk_reg         <= accept;
         usr_rej_reg     <= usr_strb & ~accept;
         lat_err_reg     <= lat_load & ~lat_ok;
         if (lat_ok)
            lat_cur_reg <= lat_clamped;
         // Stale valid bits beyond the old tap must not surface under a longer latency.
         vld_reg         <= lat_ok ? '0 : vld_next;
         tag_reg         <= tag_next;
         usr_dvld_reg    <= vld_reg[tap_idx];
         usr_tag_reg     <= tag_reg[tap_idx];
         usr_data_reg    <= phy_data;
         outstanding_reg <= outstanding_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(usr_dvld_reg && !accept && outstanding_reg == '0));
         assert (!(accept && !usr_dvld_reg && outstanding_reg == '1));
      end
   end

   assign usr_rej     = usr_rej_reg;
   assign usr_dvld    = usr_dvld_reg;
   assign usr_tag_out = usr_tag_reg;
   assign usr_data    = usr_data_reg;
   assign lat_err     = lat_err_reg;
   assign lat_cur     = lat_cur_reg;
   assign outstanding = outstanding_reg;

endmodule

// File: tb/tb_qdrc_rd_tagged.sv
// Randomized bench for qdrc_rd_tagged against a queue-based model of pending reads.
module tb_qdrc_rd_tagged;

   localparam int DW  = 36;
   localparam int TW  = 4;
   localparam int MAXL = 16;
   localparam int DEFL = 11;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              phy_rdy = 1'b0;
   logic              usr_strb = 1'b0;
   logic [TW-1:0]     usr_tag = '0;
   logic              usr_rej;
   logic              phy_strb;
   logic [2*DW-1:0]   phy_data = '0;
   logic [2*DW-1:0]   usr_data;
   logic [TW-1:0]     usr_tag_out;
   logic              usr_dvld;
   logic [4:0]        lat_cfg = '0;
   logic              lat_load = 1'b0;
   logic              lat_err;
   logic [4:0]        lat_cur;
   logic [4:0]        outstanding;

   qdrc_rd_tagged dut (
      .clk(clk), .reset(reset), .phy_rdy(phy_rdy), .usr_strb(usr_strb), .usr_tag(usr_tag),
      .usr_rej(usr_rej), .phy_strb(phy_strb), .phy_data(phy_data), .usr_data(usr_data),
      .usr_tag_out(usr_tag_out), .usr_dvld(usr_dvld), .lat_cfg(lat_cfg), .lat_load(lat_load),
      .lat_err(lat_err), .lat_cur(lat_cur), .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            due;
      logic [TW-1:0] tag;
   } pend_t;

   pend_t           pend[$];
   int              cyc = 0;
   int              lat = DEFL;
   int              last_acc = -10;
   bit              exp_rej = 0;
   bit              exp_lerr = 0;
   logic [2*DW-1:0] exp_data = '0;
   int              checks = 0;
   int              failures = 0;

   task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   function automatic int clamp_lat(input int cfg);
      if (cfg < 2) return 2;
      if (cfg > MAXL) return MAXL;
      return cfg;
   endfunction

   // One controller cycle: check this cycle's outputs, drive inputs, update the model.
   task automatic step(input bit rst, input bit strb, input bit rdy, input logic [TW-1:0] tag,
                       input bit load, input logic [4:0] cfg);
      bit exp_dvld;
      bit acc;
      bit ok;
      int outs;
      @(negedge clk);
      outs     = pend.size();
      exp_dvld = (outs > 0) && (pend[0].due == cyc);
      check_val("usr_dvld", usr_dvld, exp_dvld);
      if (exp_dvld) begin
         check_val("usr_tag_out", usr_tag_out, pend[0].tag);
         $display("cyc=%0d return tag=%0h data=%0h", cyc, usr_tag_out, usr_data);
         void'(pend.pop_front());
      end
      check_val("usr_data", usr_data, exp_data);
      check_val("usr_rej", usr_rej, exp_rej);
      check_val("lat_err", lat_err, exp_lerr);
      check_val("lat_cur", lat_cur, lat);
      check_val("outstanding", outstanding, outs);

      reset    = rst;
      usr_strb = strb;
      phy_rdy  = rdy;
      usr_tag  = tag;
      lat_load = load;
      lat_cfg  = cfg;
      phy_data = {$urandom, $urandom, $urandom};
      #1;
      acc = strb && rdy && (last_acc != cyc - 1);
      if (!rst) check_val("phy_strb", phy_strb, acc);

      if (rst) begin
         pend.delete();
         lat      = DEFL;
         last_acc = -10;
         exp_rej  = 0;
         exp_lerr = 0;
         exp_data = '0;
      end else begin
         exp_rej  = strb && !acc;
         ok       = load && (outs == 0) && !acc;
         exp_lerr = load && !ok;
         if (acc) begin
            pend.push_back('{due: cyc + lat, tag: tag});
            last_acc = cyc;
         end
         if (ok) lat = clamp_lat(int'(cfg));
         exp_data = phy_data;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1, '0, 0, '0);
   endtask

   initial begin
      repeat (3) step(1, 0, 0, '0, 0, '0);

      // single read at default latency
      step(0, 1, 1, 4'h5, 0, '0);
      idle(14);

      // held strobe: alternate accept/reject
      for (int i = 0; i < 6; i++) step(0, 1, 1, 4'(i), 0, '0);
      idle(16);

      // PHY not ready
      step(0, 1, 0, 4'h3, 0, '0);
      step(0, 1, 0, 4'h4, 0, '0);
      idle(3);

      // latency programming when idle, with clamping
      step(0, 0, 1, '0, 1, 5'd4);
      step(0, 1, 1, 4'h9, 0, '0);
      idle(6);
      step(0, 0, 1, '0, 1, 5'd1);
      idle(1);
      step(0, 0, 1, '0, 1, 5'd31);
      idle(1);
      step(0, 0, 1, '0, 1, 5'd11);
      idle(1);

      // load refused while a read is in flight
      step(0, 1, 1, 4'hA, 0, '0);
      idle(2);
      step(0, 0, 1, '0, 1, 5'd5);
      idle(14);

      // strobe and load together with nothing outstanding
      step(0, 1, 1, 4'hB, 1, 5'd6);
      idle(14);

      // reset with three reads in flight
      for (int i = 0; i < 5; i++) step(0, 1, 1, 4'(i + 1), 0, '0);
      step(1, 0, 0, '0, 0, '0);
      idle(20);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 4) != 0),
              4'($urandom),
              ($urandom_range(0, 19) == 0),
              5'($urandom));
      end
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
